byte_serial_add_ctrl: RTL

//   Multi-cycle controller that computes a DATA_W-bit add by sequencing one SLICE_W-bit

---
 rtl/byte_serial_add_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/byte_serial_add_ctrl.sv
// byte_serial_add_ctrl
// Multi-cycle DATA_W-bit adder that reuses one SLICE_W-bit ripple slice over
// NSLICE = DATA_W/SLICE_W cycles. The carry is registered between slices.
// Operands are taken with a valid/ready handshake, and the result is delivered
// the same way. The result stays held until the consumer takes it.

module byte_serial_add_ctrl #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              busy
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    // A width that does not split evenly into slices cannot be sequenced.
    generate
        if ((DATA_W % SLICE_W) != 0) begin : g_bad_width
            $error("byte_serial_add_ctrl: DATA_W must be a multiple of SLICE_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    idx_r;
    logic                carry_r;
    logic [DATA_W-1:0]   opa_r;
    logic [DATA_W-1:0]   opb_r;
    logic [DATA_W-1:0]   sum_r;
    logic                cout_r;
    logic                out_valid_r;
    logic                busy_r;
    logic                in_ready_r;

    logic [SLICE_W-1:0]  slice_a_s;
    logic [SLICE_W-1:0]  slice_b_s;
    logic [SLICE_W-1:0]  slice_sum_s;
    logic [SLICE_W:0]    chain_s;
    logic                slice_cout_s;

    // One-bit full adder, returned as {carry, sum}.
    function automatic logic [1:0] fadder(input logic x, input logic y, input logic ci);
        return {((x & y) | (x & ci) | (y & ci)), (x ^ y ^ ci)};
    endfunction

    // Select the operand slice addressed by the current slice index.
    always_comb begin
        slice_a_s = opa_r[idx_r*SLICE_W +: SLICE_W];
        slice_b_s = opb_r[idx_r*SLICE_W +: SLICE_W];
    end

    // The shared slice: a SLICE_W-bit ripple of full adders fed by the carry register.
    always_comb begin
        chain_s     = '0;
        slice_sum_s = '0;
        chain_s[0]  = carry_r;
        for (int i = 0; i < SLICE_W; i++) begin
            {chain_s[i+1], slice_sum_s[i]} = fadder(slice_a_s[i], slice_b_s[i], chain_s[i]);
        end
        slice_cout_s = chain_s[SLICE_W];
    end

    // Control FSM: accept operands, step through the slices, then hold the result until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            carry_r     <= 1'b0;
            opa_r       <= '0;
            opb_r       <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    in_ready_r <= 1'b1;
                    if (in_valid && in_ready_r) begin
                        opa_r      <= a;
                        opb_r      <= b;
                        carry_r    <= cin;
                        idx_r      <= '0;
                        sum_r      <= '0;
                        busy_r     <= 1'b1;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_r[idx_r*SLICE_W +: SLICE_W] <= slice_sum_s;
                    carry_r <= slice_cout_s;
                    if (idx_r == IDX_LAST) begin
                        // The index stops at the last slice, so it never wraps.
                        cout_r      <= slice_cout_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    idx_r       <= '0;
                    carry_r     <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign busy      = busy_r;

endmodule
